// File: rtl/hack_boot_loader_pkg.sv
// Shared definitions for the Hack boot loader: FSM encoding, frame constants, ROM geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hack_boot_loader_pkg;

    // ROM address width shared with the instruction ROM and the CPU program counter.
    localparam int ROM_ADDR_W = 15;
    localparam logic [7:0] HACK_BOOT_MAGIC = 8'hA5;
    localparam int HACK_BOOT_TIMEOUT = 1000000;

    typedef enum logic [2:0] {
        ST_WAIT_MAGIC = 3'd0,
        ST_LEN_HI     = 3'd1,
        ST_LEN_LO     = 3'd2,
        ST_DATA_HI    = 3'd3,
        ST_DATA_LO    = 3'd4,
        ST_CHECK      = 3'd5,
        ST_RUN        = 3'd6,
        ST_ERROR      = 3'd7
    } state_t;

    // True while a frame is in flight (header, payload or checksum pending).
    function automatic logic is_loading(input state_t s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    endfunction

endpackage

// File: rtl/hack_boot_loader_if.sv
// Bundle of the loader's byte input, ROM write port and CPU control/status lines.
// Latency: n/a (wires only).
// Backpressure: none; rx_valid is a one-cycle strobe the loader must always accept.
// master = boot loader side, slave = environment (uart_rx, ROM, CPU, status).
interface hack_boot_loader_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_reset;
    logic              loading;
    logic              done;
    logic              error;

    modport master (
        input  rx_data, rx_valid,
        output rom_we, rom_addr, rom_wdata, cpu_reset, loading, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  rom_we, rom_addr, rom_wdata, cpu_reset, loading, done, error
    );
endinterface

// File: rtl/hack_boot_loader_timeout_counter.sv
// Idle-gap watchdog: counts enabled clocks without activity, flags when LIMIT is reached.
// Latency: expired is combinational on the clock whose edge would make the count reach LIMIT.
// Backpressure: none; clr (activity) always wins over expiry.
// Ports: clk, reset (async active-high), en (count allowed), clr (activity seen), expired.
module hack_timeout_counter #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Flag one cycle early so the owner's state changes on the LIMIT-th idle edge.
    assign expired = en && !clr && (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!en || clr || expired) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/hack_boot_loader.sv
// Boot loader: parses a MAGIC/LEN/words/CSUM byte frame, writes words to ROM, releases the CPU.
// Latency: rom_we one cycle after each DATA_LO strobe; cpu_reset drops the cycle after CSUM.
// Backpressure: none; accepts one byte every cycle, idle gaps longer than TIMEOUT_CYC abort.
// Ports: clk, reset (async active-high), bus (master: rx in, ROM write port / cpu_reset / status out).
module hack_boot_loader
    import hack_boot_loader_pkg::*;
#(
    parameter int         ADDR_W      = ROM_ADDR_W,
    parameter logic [7:0] MAGIC       = HACK_BOOT_MAGIC,
    parameter int         TIMEOUT_CYC = HACK_BOOT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    hack_boot_loader_if.master  bus
);
    state_t            state, state_nxt;
    logic [7:0]        csum;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [7:0]        hi_byte;
    // One extra bit so a full-depth image finishes without the index wrapping.
    logic [ADDR_W:0]   word_idx;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;

    logic              tmo_expired;
    logic [15:0]       len_full;
    logic              len_ok;
    logic              last_word;
    logic              is_magic;

    assign len_full  = {len_hi, bus.rx_data};
    assign len_ok    = (len_full != 16'd0) && (32'(len_full) <= (32'd1 << ADDR_W));
    assign last_word = (32'(word_idx) + 32'd1) == 32'(len);
    assign is_magic  = bus.rx_data == MAGIC;

    hack_timeout_counter #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .en      (is_loading(state)),
        .clr     (bus.rx_valid),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT_MAGIC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (tmo_expired) begin
            state_nxt = ST_ERROR;
        end else if (bus.rx_valid) begin
            case (state)
                ST_WAIT_MAGIC, ST_RUN, ST_ERROR: if (is_magic) state_nxt = ST_LEN_HI;
                ST_LEN_HI:  state_nxt = ST_LEN_LO;
                ST_LEN_LO:  state_nxt = len_ok ? ST_DATA_HI : ST_ERROR;
                ST_DATA_HI: state_nxt = ST_DATA_LO;
                ST_DATA_LO: state_nxt = last_word ? ST_CHECK : ST_DATA_HI;
                ST_CHECK:   state_nxt = (bus.rx_data == csum) ? ST_RUN : ST_ERROR;
                default:    state_nxt = ST_ERROR;
            endcase
        end
    end

    // Frame datapath: checksum, length and payload word assembly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum     <= '0;
            len_hi   <= '0;
            len      <= '0;
            hi_byte  <= '0;
            word_idx <= '0;
        end else if (bus.rx_valid) begin
            case (state)
                ST_WAIT_MAGIC, ST_RUN, ST_ERROR: begin
                    if (is_magic) begin
                        csum     <= '0;
                        word_idx <= '0;
                    end
                end
                ST_LEN_HI: begin
                    len_hi <= bus.rx_data;
                    csum   <= csum ^ bus.rx_data;
                end
                ST_LEN_LO: begin
                    len  <= len_full;
                    csum <= csum ^ bus.rx_data;
                end
                ST_DATA_HI: begin
                    hi_byte <= bus.rx_data;
                    csum    <= csum ^ bus.rx_data;
                end
                ST_DATA_LO: begin
                    csum     <= csum ^ bus.rx_data;
                    word_idx <= word_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ROM write port: one registered pulse per completed word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (bus.rx_valid && state == ST_DATA_LO) begin
                we_q    <= 1'b1;
                addr_q  <= word_idx[ADDR_W-1:0];
                wdata_q <= {hi_byte, bus.rx_data};
            end
        end
    end

    // Outputs: decoded from registered state only.
    always_comb begin
        bus.rom_we    = we_q;
        bus.rom_addr  = addr_q;
        bus.rom_wdata = wdata_q;
        bus.loading   = is_loading(state);
        bus.done      = state == ST_RUN;
        bus.error     = state == ST_ERROR;
        bus.cpu_reset = state != ST_RUN;
    end
endmodule
